pipe_fwd_reg: RTL and testbench
===============================

# pipe_fwd_reg

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush, and multi-port writeback forwarding into held source operands. It generalises the decode-to-execute segment register to any stage boundary in the core. It keeps captured operands current while an entry waits, using NUM_WB writeback ports, and handles NUM_SRC operand slots per entry.

## Interface
- PAYLOAD_W, default 128: width of opaque control/payload bits passed through untouched.
- NUM_SRC, default 2: operand slots per entry (rs, rt, ...).
- NUM_WB, default 1: writeback ports snooped for forwarding.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of both entries; same cycle-effect as reset.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  entry accepted when in_valid & in_ready.
- in_payload  input  PAYLOAD_W  pass-through bits.
- in_opnd  input  NUM_SRC*32  operand values, slot i at [32i+31:32i].
- in_tag  input  NUM_SRC*5  source register number per slot.
- in_ren  input  NUM_SRC  slot actually reads a register (forwarding enable).
- wb_en  input  NUM_WB  writeback port j writes this cycle.
- wb_reg  input  NUM_WB*5  destination register per port.
- wb_data  input  NUM_WB*32  write data per port.
- out_valid  output  1  main entry present.
- out_ready  input  1  downstream accepts; fire = out_valid & out_ready.
- out_payload  output  PAYLOAD_W  main entry payload.
- out_opnd  output  NUM_SRC*32  main entry operands, forwarding already applied.
- out_tag  output  NUM_SRC*5; out_ren  output  NUM_SRC  main entry tags and enables.

## Operation
- Two storage entries: main (drives out_*) and skid. State is EMPTY, ONE (main valid), or FULL (main and skid valid).
- in_ready = !skid_valid & !reset. It is a registered-state function, not combinational on out_ready.
- Transitions, with in fire = in_valid & in_ready and out fire = out_valid & out_ready:
  - EMPTY + in fire -> ONE; main <= in.
  - ONE + in & out fire -> ONE; main <= in.
  - ONE + in fire only -> FULL; skid <= in.
  - ONE + out fire only -> EMPTY.
  - FULL + out fire -> ONE; main <= skid.
  - Otherwise hold.
- reset or flush: go to EMPTY; all stored payload, operands, tags and ren are zeroed. flush overrides a simultaneous in fire (input dropped) and out fire. out_valid is still high in the flush cycle, so downstream must qualify with flush.
- Forwarding match for slot i against port j: wb_en[j] & ren[i] & (tag[i] == wb_reg[j]) & (tag[i] != 0).
  - If several ports match, the highest index j wins.
- Forwarding is applied:
  - at capture: the value written into main/skid is the forwarded in_opnd;
  - every cycle to each held, valid entry not being overwritten that cycle;
  - in the FULL->ONE move: skid operands are forwarded while moving into main.
- Forwarding never changes tag, ren or payload.

## Timing
- Latency: in fire at cycle N -> out_valid at N+1 with that entry.
- Throughput: one entry per cycle when out_ready stays high.
- in_ready falls the cycle after the skid fills and rises the cycle after out fire in FULL.
- Reset values: out_valid 0, out_payload 0, out_opnd 0, out_tag 0, out_ren 0, in_ready 0 while reset is high and 1 the following cycle.
- A writeback in cycle N affects the stored operand from cycle N+1. out_opnd is never combinationally bypassed from wb_* in the same cycle.
- Entry ordering is strict FIFO, depth 2; no entry is ever duplicated or reordered.

## Structure
- Shared package pipe_pkg: REG_W = 5, DATA_W = 32, and the zero-register constant.
- One sub-module, pipe_fwd_sel: combinational select for a single operand slot over NUM_WB ports, implementing the highest-index-wins rule. It is instantiated per slot for the input path, the main entry and the skid entry.

## Test plan
- Basic flow: NUM_SRC=2, NUM_WB=2, out_ready=1; stream 4 entries back-to-back -> each appears 1 cycle later, in_ready stays 1, payloads in order.
- Backpressure: out_ready=0, push A, B, C -> in_ready=0 after B; C held upstream. Raise out_ready -> A, B, C emerge in order with no loss.
- Held forwarding: main holds tag 3 ren=1 with value 0x11, out_ready=0; wb_en=1, wb_reg=3, wb_data=0xDEADBEEF -> out_opnd slot shows 0xDEADBEEF next cycle. Same with tag 0 or ren=0 -> value unchanged.
- Port priority: ports 0 and 1 both write reg 7 (0xA, 0xB) while an entry with tag 7 is held -> stored 0xB. Repeat while entry moves skid->main -> main gets 0xB.
- Capture forwarding: in fire with tag 5 and in_opnd 0x1, same-cycle wb reg 5 = 0x99 -> out_opnd 0x99.
- Flush/reset mid-operation: FULL state, assert flush together with in_valid and out_ready -> next cycle out_valid=0, in_ready=1, outputs zero. Same check with reset.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, zero-register constant and occupancy encoding for the
// forwarding pipeline-stage register.
package pipe_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fwd_state_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Writeback forwarding select for one operand slot; when several ports hit
// the same register, the highest-numbered port supplies the value.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_WB = 1
) (
  input  logic [DATA_W-1:0]        i_opnd,
  input  logic [REG_W-1:0]         i_tag,
  input  logic                     i_ren,
  input  logic [NUM_WB-1:0]        i_wb_en,
  input  logic [NUM_WB*REG_W-1:0]  i_wb_reg,
  input  logic [NUM_WB*DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0]        o_opnd
);

  // Ascending scan: a later match overwrites an earlier one.
  always_comb begin
    o_opnd = i_opnd;
    for (int unsigned j = 0; j < NUM_WB; j++) begin
      if (i_wb_en[j] && i_ren && (i_tag != ZERO_REG) &&
          (i_tag == i_wb_reg[j*REG_W +: REG_W])) begin
        o_opnd = i_wb_data[j*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/pipe_fwd_reg.sv
// Two-entry (main + skid) pipeline-stage register with valid/ready handshake,
// synchronous flush and writeback forwarding into held source operands.
module pipe_fwd_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned NUM_WB    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_W-1:0]     in_payload,
  input  logic [NUM_SRC*32-1:0]    in_opnd,
  input  logic [NUM_SRC*5-1:0]     in_tag,
  input  logic [NUM_SRC-1:0]       in_ren,
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [NUM_WB*5-1:0]      wb_reg,
  input  logic [NUM_WB*32-1:0]     wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_W-1:0]     out_payload,
  output logic [NUM_SRC*32-1:0]    out_opnd,
  output logic [NUM_SRC*5-1:0]     out_tag,
  output logic [NUM_SRC-1:0]       out_ren
);

  localparam int unsigned OPW = NUM_SRC * DATA_W;
  localparam int unsigned TGW = NUM_SRC * REG_W;

  fwd_state_e           r_state;

  logic [PAYLOAD_W-1:0] r_main_payload;
  logic [OPW-1:0]       r_main_opnd;
  logic [TGW-1:0]       r_main_tag;
  logic [NUM_SRC-1:0]   r_main_ren;

  logic [PAYLOAD_W-1:0] r_skid_payload;
  logic [OPW-1:0]       r_skid_opnd;
  logic [TGW-1:0]       r_skid_tag;
  logic [NUM_SRC-1:0]   r_skid_ren;

  logic [OPW-1:0]       w_in_fwd;
  logic [OPW-1:0]       w_main_fwd;
  logic [OPW-1:0]       w_skid_fwd;
  logic                 w_in_fire;
  logic                 w_out_fire;

  // in_ready depends only on stored occupancy (and reset), never on out_ready.
  assign in_ready    = (r_state != ST_FULL) && !reset;
  assign out_valid   = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = out_valid && out_ready;

  assign out_payload = r_main_payload;
  assign out_opnd    = r_main_opnd;
  assign out_tag     = r_main_tag;
  assign out_ren     = r_main_ren;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    pipe_fwd_sel #(.NUM_WB(NUM_WB)) u_sel_in (
      .i_opnd    (in_opnd[g*DATA_W +: DATA_W]),
      .i_tag     (in_tag[g*REG_W +: REG_W]),
      .i_ren     (in_ren[g]),
      .i_wb_en   (wb_en),
      .i_wb_reg  (wb_reg),
      .i_wb_data (wb_data),
      .o_opnd    (w_in_fwd[g*DATA_W +: DATA_W])
    );

    pipe_fwd_sel #(.NUM_WB(NUM_WB)) u_sel_main (
      .i_opnd    (r_main_opnd[g*DATA_W +: DATA_W]),
      .i_tag     (r_main_tag[g*REG_W +: REG_W]),
      .i_ren     (r_main_ren[g]),
      .i_wb_en   (wb_en),
      .i_wb_reg  (wb_reg),
      .i_wb_data (wb_data),
      .o_opnd    (w_main_fwd[g*DATA_W +: DATA_W])
    );

    pipe_fwd_sel #(.NUM_WB(NUM_WB)) u_sel_skid (
      .i_opnd    (r_skid_opnd[g*DATA_W +: DATA_W]),
      .i_tag     (r_skid_tag[g*REG_W +: REG_W]),
      .i_ren     (r_skid_ren[g]),
      .i_wb_en   (wb_en),
      .i_wb_reg  (wb_reg),
      .i_wb_data (wb_data),
      .o_opnd    (w_skid_fwd[g*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state        <= ST_EMPTY;
      r_main_payload <= '0;
      r_main_opnd    <= '0;
      r_main_tag     <= '0;
      r_main_ren     <= '0;
      r_skid_payload <= '0;
      r_skid_opnd    <= '0;
      r_skid_tag     <= '0;
      r_skid_ren     <= '0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state        <= ST_ONE;
            r_main_payload <= in_payload;
            r_main_opnd    <= w_in_fwd;
            r_main_tag     <= in_tag;
            r_main_ren     <= in_ren;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_payload <= in_payload;
            r_main_opnd    <= w_in_fwd;
            r_main_tag     <= in_tag;
            r_main_ren     <= in_ren;
          end else if (w_in_fire) begin
            r_state        <= ST_FULL;
            r_skid_payload <= in_payload;
            r_skid_opnd    <= w_in_fwd;
            r_skid_tag     <= in_tag;
            r_skid_ren     <= in_ren;
            r_main_opnd    <= w_main_fwd;
          end else if (w_out_fire) begin
            r_state        <= ST_EMPTY;
          end else begin
            r_main_opnd    <= w_main_fwd;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state        <= ST_ONE;
            r_main_payload <= r_skid_payload;
            r_main_opnd    <= w_skid_fwd;
            r_main_tag     <= r_skid_tag;
            r_main_ren     <= r_skid_ren;
          end else begin
            r_main_opnd    <= w_main_fwd;
            r_skid_opnd    <= w_skid_fwd;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fwd_reg.sv
// Directed, table-driven bench for pipe_fwd_reg (NUM_SRC=2, NUM_WB=2).
module tb_pipe_fwd_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_payload;
  logic [63:0] in_opnd;
  logic [9:0]  in_tag;
  logic [1:0]  in_ren;
  logic [1:0]  wb_en;
  logic [9:0]  wb_reg;
  logic [63:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_payload;
  logic [63:0] out_opnd;
  logic [9:0]  out_tag;
  logic [1:0]  out_ren;

  int n_checks;
  int n_errors;

  pipe_fwd_reg #(.PAYLOAD_W(16), .NUM_SRC(2), .NUM_WB(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_opnd     (in_opnd),
    .in_tag      (in_tag),
    .in_ren      (in_ren),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_opnd    (out_opnd),
    .out_tag     (out_tag),
    .out_ren     (out_ren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [15:0] pay;
    logic [63:0] opnd;
    logic [9:0]  tag;
    logic [1:0]  ren;
    logic [1:0]  wen;
    logic [9:0]  wreg;
    logic [63:0] wdat;
    logic        e_ov;
    logic        e_ir;
    logic        chk;
    logic [15:0] e_pay;
    logic [63:0] e_opnd;
    logic [9:0]  e_tag;
    logic [1:0]  e_ren;
  } vec_t;

  vec_t tbl [26];

  task automatic check(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid   = v.iv;
    out_ready  = v.ordy;
    flush      = v.fl;
    in_payload = v.pay;
    in_opnd    = v.opnd;
    in_tag     = v.tag;
    in_ren     = v.ren;
    wb_en      = v.wen;
    wb_reg     = v.wreg;
    wb_data    = v.wdat;
  endtask

  task automatic push(input logic [15:0] p, input logic ordy);
    in_valid   = 1'b1;
    out_ready  = ordy;
    flush      = 1'b0;
    in_payload = p;
    in_opnd    = {16'h0, p, 16'h0, p};
    in_tag     = '0;
    in_ren     = '0;
    wb_en      = '0;
    wb_reg     = '0;
    wb_data    = '0;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_payload"}, 0, 64'(out_payload), 64'h0);
    check({nm, "_opnd"},    0, out_opnd,          64'h0);
    check({nm, "_tag"},     0, 64'(out_tag),      64'h0);
    check({nm, "_ren"},     0, 64'(out_ren),      64'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Basic flow: back-to-back stream with out_ready high.
    tbl[0]  = '{1,1,0,16'h0001,{32'h1001,32'h1000},{5'd2,5'd1},2'b00,2'b00,10'd0,64'h0,
                1,1,1,16'h0001,{32'h1001,32'h1000},{5'd2,5'd1},2'b00};
    tbl[1]  = '{1,1,0,16'h0002,{32'h2001,32'h2000},{5'd4,5'd3},2'b00,2'b00,10'd0,64'h0,
                1,1,1,16'h0002,{32'h2001,32'h2000},{5'd4,5'd3},2'b00};
    tbl[2]  = '{1,1,0,16'h0003,{32'h3001,32'h3000},{5'd6,5'd5},2'b00,2'b00,10'd0,64'h0,
                1,1,1,16'h0003,{32'h3001,32'h3000},{5'd6,5'd5},2'b00};
    tbl[3]  = '{1,1,0,16'h0004,{32'h4001,32'h4000},{5'd8,5'd7},2'b00,2'b00,10'd0,64'h0,
                1,1,1,16'h0004,{32'h4001,32'h4000},{5'd8,5'd7},2'b00};
    tbl[4]  = '{0,1,0,16'h0,64'h0,10'd0,2'b00,2'b00,10'd0,64'h0,
                0,1,0,16'h0,64'h0,10'd0,2'b00};
    // Backpressure: A, B fill both entries, C waits upstream.
    tbl[5]  = '{1,0,0,16'h000A,{32'hA1,32'hA0},{5'd2,5'd1},2'b00,2'b00,10'd0,64'h0,
                1,1,1,16'h000A,{32'hA1,32'hA0},{5'd2,5'd1},2'b00};
    tbl[6]  = '{1,0,0,16'h000B,{32'hB1,32'hB0},{5'd4,5'd3},2'b00,2'b00,10'd0,64'h0,
                1,0,1,16'h000A,{32'hA1,32'hA0},{5'd2,5'd1},2'b00};
    tbl[7]  = '{1,0,0,16'h000C,{32'hC1,32'hC0},{5'd6,5'd5},2'b00,2'b00,10'd0,64'h0,
                1,0,1,16'h000A,{32'hA1,32'hA0},{5'd2,5'd1},2'b00};
    tbl[8]  = '{1,1,0,16'h000C,{32'hC1,32'hC0},{5'd6,5'd5},2'b00,2'b00,10'd0,64'h0,
                1,1,1,16'h000B,{32'hB1,32'hB0},{5'd4,5'd3},2'b00};
    tbl[9]  = '{1,1,0,16'h000C,{32'hC1,32'hC0},{5'd6,5'd5},2'b00,2'b00,10'd0,64'h0,
                1,1,1,16'h000C,{32'hC1,32'hC0},{5'd6,5'd5},2'b00};
    tbl[10] = '{0,1,0,16'h0,64'h0,10'd0,2'b00,2'b00,10'd0,64'h0,
                0,1,0,16'h0,64'h0,10'd0,2'b00};
    // Held forwarding into main slot 0 (tag 3).
    tbl[11] = '{1,0,0,16'h0011,{32'h22,32'h11},{5'd4,5'd3},2'b11,2'b00,10'd0,64'h0,
                1,1,1,16'h0011,{32'h22,32'h11},{5'd4,5'd3},2'b11};
    tbl[12] = '{0,0,0,16'h0,64'h0,10'd0,2'b00,2'b01,{5'd0,5'd3},{32'h0,32'hDEADBEEF},
                1,1,1,16'h0011,{32'h22,32'hDEADBEEF},{5'd4,5'd3},2'b11};
    tbl[13] = '{0,0,0,16'h0,64'h0,10'd0,2'b00,2'b00,10'd0,64'h0,
                1,1,1,16'h0011,{32'h22,32'hDEADBEEF},{5'd4,5'd3},2'b11};
    tbl[14] = '{0,1,0,16'h0,64'h0,10'd0,2'b00,2'b00,10'd0,64'h0,
                0,1,0,16'h0,64'h0,10'd0,2'b00};
    // Tag 0 (slot 0) and ren=0 (slot 1) must not forward.
    tbl[15] = '{1,0,0,16'h0015,{32'h66,32'h55},{5'd6,5'd0},2'b01,2'b00,10'd0,64'h0,
                1,1,1,16'h0015,{32'h66,32'h55},{5'd6,5'd0},2'b01};
    tbl[16] = '{0,0,0,16'h0,64'h0,10'd0,2'b00,2'b11,{5'd6,5'd0},{32'h5678,32'h1234},
                1,1,1,16'h0015,{32'h66,32'h55},{5'd6,5'd0},2'b01};
    tbl[17] = '{0,1,0,16'h0,64'h0,10'd0,2'b00,2'b00,10'd0,64'h0,
                0,1,0,16'h0,64'h0,10'd0,2'b00};
    // Port priority on held main, then on the skid->main move.
    tbl[18] = '{1,0,0,16'h0018,{32'h2,32'h1},{5'd0,5'd7},2'b01,2'b00,10'd0,64'h0,
                1,1,1,16'h0018,{32'h2,32'h1},{5'd0,5'd7},2'b01};
    tbl[19] = '{0,0,0,16'h0,64'h0,10'd0,2'b00,2'b11,{5'd7,5'd7},{32'hB,32'hA},
                1,1,1,16'h0018,{32'h2,32'hB},{5'd0,5'd7},2'b01};
    tbl[20] = '{1,0,0,16'h0020,{32'h4,32'h3},{5'd0,5'd7},2'b01,2'b00,10'd0,64'h0,
                1,0,1,16'h0018,{32'h2,32'hB},{5'd0,5'd7},2'b01};
    tbl[21] = '{0,1,0,16'h0,64'h0,10'd0,2'b00,2'b11,{5'd7,5'd7},{32'hB,32'hA},
                1,1,1,16'h0020,{32'h4,32'hB},{5'd0,5'd7},2'b01};
    tbl[22] = '{0,1,0,16'h0,64'h0,10'd0,2'b00,2'b00,10'd0,64'h0,
                0,1,0,16'h0,64'h0,10'd0,2'b00};
    // Capture forwarding, then fill and flush with in/out fire pending.
    tbl[23] = '{1,0,0,16'h0023,{32'h77,32'h1},{5'd0,5'd5},2'b01,2'b01,{5'd0,5'd5},{32'h0,32'h99},
                1,1,1,16'h0023,{32'h77,32'h99},{5'd0,5'd5},2'b01};
    tbl[24] = '{1,0,0,16'h0024,{32'h88,32'h2},{5'd0,5'd0},2'b00,2'b00,10'd0,64'h0,
                1,0,1,16'h0023,{32'h77,32'h99},{5'd0,5'd5},2'b01};
    tbl[25] = '{1,1,1,16'h0025,{32'h99,32'h3},{5'd2,5'd1},2'b11,2'b00,10'd0,64'h0,
                0,1,1,16'h0,64'h0,10'd0,2'b00};

    reset = 1'b1;
    push(16'h0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 0, 64'(out_valid), 64'h0);
    check("rst_in_ready",  0, 64'(in_ready),  64'h0);
    check_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready",  0, 64'(in_ready),  64'h1);
    check("post_rst_out_valid", 0, 64'(out_valid), 64'h0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check("out_valid", i, 64'(out_valid), 64'(tbl[i].e_ov));
      check("in_ready",  i, 64'(in_ready),  64'(tbl[i].e_ir));
      if (tbl[i].chk) begin
        check("out_payload", i, 64'(out_payload), 64'(tbl[i].e_pay));
        check("out_opnd",    i, out_opnd,          tbl[i].e_opnd);
        check("out_tag",     i, 64'(out_tag),      64'(tbl[i].e_tag));
        check("out_ren",     i, 64'(out_ren),      64'(tbl[i].e_ren));
      end
    end

    // Reset mid-operation from FULL with in/out fire pending.
    @(negedge clk); push(16'h0031, 1'b0);
    @(negedge clk); push(16'h0032, 1'b0);
    @(posedge clk); #1;
    check("seq_full_in_ready", 0, 64'(in_ready), 64'h0);
    @(negedge clk);
    push(16'h0033, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("seq_rst_out_valid", 0, 64'(out_valid), 64'h0);
    check("seq_rst_in_ready",  0, 64'(in_ready),  64'h0);
    check_zero("seq_rst");
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("seq_rel_in_ready",  0, 64'(in_ready),  64'h1);
    check("seq_rel_out_valid", 0, 64'(out_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
